// File: rtl/lfsr_checker.sv
// Receive-end checker for the 8-bit LFSR lab stream: self-seeds, predicts each bit, counts mismatches.
// Define LFSR_CHK_SEG_EN to drive the hex 7-segment decode of err_cnt; otherwise seg0/seg1 stay dark.
//
// state | meaning
// SEED  | collecting 8 history bits; waits for a nonzero history
// CHECK | locked; each accepted bit is compared with the prediction
module lfsr_checker #(
   parameter int unsigned LOSS_THRESH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bit_valid,
   input  logic       bit_in,
   input  logic       clr,
   output logic       locked,
   output logic       err_pulse,
   output logic [7:0] err_cnt,
   output logic [7:0] seg0,
   output logic [7:0] seg1
);

   localparam logic [3:0] THRESH = 4'(LOSS_THRESH);

   typedef enum logic {SEED, CHECK} state_t;

   state_t     state_q, state_d;
   logic [3:0] fill_q, fill_d;
   logic [7:0] h_q, h_d;
   logic [3:0] miss_run_q, miss_run_d;
   logic       locked_q, locked_d;
   logic       err_pulse_q, err_pulse_d;
   logic [7:0] err_cnt_q, err_cnt_d;

   logic [7:0] h_next;
   logic [3:0] fill_inc;
   logic       pred;
   logic       miss;

   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      h_d         = h_q;
      miss_run_d  = miss_run_q;
      err_pulse_d = 1'b0;
      err_cnt_d   = err_cnt_q;

      h_next   = {h_q[6:0], bit_in};
      pred     = h_q[3] ^ h_q[4] ^ h_q[5] ^ h_q[7];
      miss     = bit_in ^ pred;
      fill_inc = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;

      if (bit_valid) begin
         h_d = h_next;
         case (state_q)
            SEED: begin
               // an all-zero history is the generator lock-up state, so keep seeding
               fill_d = fill_inc;
               if (fill_inc == 4'd8 && h_next != 8'h00) begin
                  state_d    = CHECK;
                  miss_run_d = 4'd0;
               end
            end
            CHECK: begin
               if (miss) begin
                  err_pulse_d = 1'b1;
                  if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                  if ((miss_run_q + 4'd1) == THRESH) begin
                     state_d    = SEED;
                     fill_d     = 4'd0;
                     miss_run_d = 4'd0;
                  end else begin
                     miss_run_d = miss_run_q + 4'd1;
                  end
               end else begin
                  miss_run_d = 4'd0;
               end
            end
            default: state_d = SEED;
         endcase
      end

      if (clr) err_cnt_d = 8'h00;
      locked_d = (state_d == CHECK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SEED;
         fill_q      <= 4'd0;
         h_q         <= 8'h00;
         miss_run_q  <= 4'd0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         h_q         <= h_d;
         miss_run_q  <= miss_run_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;

`ifdef LFSR_CHK_SEG_EN
   function automatic logic [7:0] hex_seg(input logic [3:0] v);
      logic [7:0] pat;
      case (v)
         4'h0: pat = 8'hFC;
         4'h1: pat = 8'h60;
         4'h2: pat = 8'hDA;
         4'h3: pat = 8'hF2;
         4'h4: pat = 8'h66;
         4'h5: pat = 8'hB6;
         4'h6: pat = 8'hBE;
         4'h7: pat = 8'hE0;
         4'h8: pat = 8'hFE;
         4'h9: pat = 8'hF6;
         4'hA: pat = 8'hEE;
         4'hB: pat = 8'h3E;
         4'hC: pat = 8'h9C;
         4'hD: pat = 8'h7A;
         4'hE: pat = 8'h9E;
         default: pat = 8'h8E;
      endcase
      return ~pat;
   endfunction

   assign seg0 = hex_seg(err_cnt_q[3:0]);
   assign seg1 = hex_seg(err_cnt_q[7:4]);
`else
   assign seg0 = 8'hFF;
   assign seg1 = 8'hFF;
`endif

endmodule
